// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the data memory responder
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int WORD_BYTES = 2;
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_word_ram.sv
// rtl/mem_word_ram.sv - word RAM, one byte-lane-enabled sync write port, one sync read port
//
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   wr_be / wr_addr /   per-lane write enables, word address, write data
//   wr_data
//   rd_en / rd_addr     read strobe and word address
//   rd_data             registered read data, held between reads
module mem_word_ram #(
    parameter int AW    = 7,
    parameter int DW    = 16,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] wr_be,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [DW-1:0]    rd_data
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;

    // Array contents are deliberately not reset so a loaded image survives rst_n.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_be[i]) begin
                mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU memory bus responder with wait states and byte loader
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   mem_req/mem_we/mem_addr/      bus request (level), write flag, byte address,
//   mem_in                        full-word write data
//   mem_out/mem_ready             read data (held), one-cycle response strobe
//   ld_clear/ld_valid/ld_byte/    loader pointer clear, byte stream in,
//   ld_ready                      byte-accept indication
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_in,
    output logic [DATA_W-1:0] mem_out,
    output logic              mem_ready,
    input  logic              ld_clear,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready
);

    localparam int WADDR_W = ADDR_W - 1;

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    req_we_q, req_we_d;
    logic [WADDR_W-1:0]      req_addr_q, req_addr_d;
    logic [DATA_W-1:0]       req_data_q, req_data_d;
    logic [ADDR_W-1:0]       ld_ptr_q, ld_ptr_d;

    logic                    acc_go;
    logic                    acc_we;
    logic [WADDR_W-1:0]      acc_addr;
    logic [DATA_W-1:0]       acc_data;

    logic [WORD_BYTES-1:0]   ram_be;
    logic [WADDR_W-1:0]      ram_waddr;
    logic [DATA_W-1:0]       ram_wdata;
    logic                    ram_rd_en;
    logic                    ld_ready_c;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        acc_go     = 1'b0;
        acc_we     = req_we_q;
        acc_addr   = req_addr_q;
        acc_data   = req_data_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    req_we_d   = mem_we;
                    req_addr_d = mem_addr[ADDR_W-1:1];
                    req_data_d = mem_in;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
                    end else begin
                        // No wait states: access on this edge straight from the bus.
                        state_d  = ST_RESP;
                        acc_go   = 1'b1;
                        acc_we   = mem_we;
                        acc_addr = mem_addr[ADDR_W-1:1];
                        acc_data = mem_in;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    acc_go  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Loader only runs in IDLE with no bus request, so it never collides
    // with a bus access on the single RAM write port.
    assign ld_ready_c = (state_q == ST_IDLE) & ~mem_req & ~ld_clear;

    always_comb begin
        ld_ptr_d  = ld_ptr_q;
        ram_be    = '0;
        ram_waddr = acc_addr;
        ram_wdata = acc_data;
        ram_rd_en = 1'b0;

        if (ld_clear) begin
            ld_ptr_d = '0;
        end else if (ld_valid && ld_ready_c) begin
            ld_ptr_d  = ld_ptr_q + 1'b1;
            ram_be    = ld_ptr_q[0] ? 2'b10 : 2'b01;
            ram_waddr = ld_ptr_q[ADDR_W-1:1];
            ram_wdata = {WORD_BYTES{ld_byte}};
        end

        if (acc_go) begin
            if (acc_we) begin
                ram_be = '1;
            end else begin
                ram_rd_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            ld_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_we_q   <= req_we_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            ld_ptr_q   <= ld_ptr_d;
        end
    end

    mem_word_ram #(
        .AW    (WADDR_W),
        .DW    (DATA_W),
        .LANES (WORD_BYTES)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_be   (ram_be),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (ram_rd_en),
        .rd_addr (acc_addr),
        .rd_data (mem_out)
    );

    assign mem_ready = (state_q == ST_RESP);
    assign ld_ready  = ld_ready_c;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req, we, rdy, ld_clear, ld_valid, ld_ready;
    logic [7:0]  addr, ld_byte;
    logic [15:0] din, dout;

    logic        req0, we0, rdy0, ld_clear0, ld_valid0, ld_ready0;
    logic [7:0]  addr0, ld_byte0;
    logic [15:0] din0, dout0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(req), .mem_we(we), .mem_addr(addr), .mem_in(din),
        .mem_out(dout), .mem_ready(rdy),
        .ld_clear(ld_clear), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready)
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .mem_req(req0), .mem_we(we0), .mem_addr(addr0), .mem_in(din0),
        .mem_out(dout0), .mem_ready(rdy0),
        .ld_clear(ld_clear0), .ld_valid(ld_valid0), .ld_byte(ld_byte0), .ld_ready(ld_ready0)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] din;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus access on the WAIT_STATES=1 instance: checks latency, data, pulse width, hold.
    task automatic bus_op(input logic w, input logic [7:0] a, input logic [15:0] d,
                          input logic [15:0] exp_out, input string name);
        int lat;
        bit seen;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; din = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        check({name, "_rdy_early"}, 32'(rdy), 32'd0);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (rdy) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'd1);
        check({name, "_data"}, 32'(dout), 32'(exp_out));
        @(posedge clk); #1;
        check({name, "_rdy_width"}, 32'(rdy), 32'd0);
        check({name, "_hold"}, 32'(dout), 32'(exp_out));
    endtask

    task automatic ld_push(input logic [7:0] b, input string name);
        @(negedge clk);
        ld_valid = 1'b1; ld_byte = b;
        #1;
        check({name, "_ld_ready"}, 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [5:0] pat;

        rst_n = 1'b0;
        req = 0; we = 0; addr = 0; din = 0; ld_clear = 0; ld_valid = 0; ld_byte = 0;
        req0 = 0; we0 = 0; addr0 = 0; din0 = 0; ld_clear0 = 0; ld_valid0 = 0; ld_byte0 = 0;

        vecs[0]  = '{1'b1, 8'h02, 16'h5A5A, 16'h1234};
        vecs[1]  = '{1'b1, 8'h04, 16'h1111, 16'h1234};
        vecs[2]  = '{1'b1, 8'h08, 16'h2222, 16'h1234};
        vecs[3]  = '{1'b1, 8'h06, 16'hBEEF, 16'h1234};
        vecs[4]  = '{1'b0, 8'h07, 16'h0000, 16'hBEEF};
        vecs[5]  = '{1'b0, 8'h05, 16'h0000, 16'h1111};
        vecs[6]  = '{1'b0, 8'h09, 16'h0000, 16'h2222};
        vecs[7]  = '{1'b0, 8'h02, 16'h0000, 16'h5A5A};
        vecs[8]  = '{1'b0, 8'h00, 16'h0000, 16'h1234};
        vecs[9]  = '{1'b1, 8'h06, 16'hC0DE, 16'h1234};
        vecs[10] = '{1'b0, 8'h06, 16'h0000, 16'hC0DE};
        vecs[11] = '{1'b0, 8'h03, 16'h0000, 16'h5A5A};

        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_ready", 32'(rdy), 32'd0);
        check("reset_mem_out", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_ld_ready", 32'(ld_ready), 32'd1);

        // Boot two bytes, then read the word back.
        ld_push(8'h34, "load0");
        ld_push(8'h12, "load1");
        bus_op(1'b0, 8'h00, 16'h0000, 16'h1234, "read_boot");

        for (int i = 0; i < 12; i++) begin
            bus_op(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp_out,
                   $sformatf("vec%0d", i));
        end

        // Bus request and loader byte in the same IDLE cycle: bus wins.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 8'h00;
        ld_valid = 1'b1; ld_byte = 8'h77;
        #1;
        check("arb_ld_ready_idle", 32'(ld_ready), 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        check("arb_ld_ready_wait", 32'(ld_ready), 32'd0);
        check("arb_rdy_wait", 32'(rdy), 32'd0);
        @(posedge clk); #1;
        check("arb_rdy_resp", 32'(rdy), 32'd1);
        check("arb_data", 32'(dout), 32'h1234);
        check("arb_ld_ready_resp", 32'(ld_ready), 32'd0);
        @(posedge clk); #1;
        check("arb_ld_ready_back", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        bus_op(1'b0, 8'h02, 16'h0000, 16'h5A77, "arb_lane0");

        // 257-byte stream wraps the 8-bit pointer.
        @(negedge clk);
        ld_clear = 1'b1;
        #1;
        check("clear_ld_ready", 32'(ld_ready), 32'd0);
        @(negedge clk);
        ld_clear = 1'b0;
        bad = 0;
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_byte  = i[7:0];
            #1;
            if (!ld_ready) bad++;
        end
        @(negedge clk);
        ld_valid = 1'b0;
        check("stream_ld_ready", 32'(bad), 32'd0);
        bus_op(1'b0, 8'h00, 16'h0000, 16'h0100, "wrap_word0");
        bus_op(1'b0, 8'h02, 16'h0000, 16'h0302, "wrap_word1");
        ld_push(8'hAB, "ptr_one");
        bus_op(1'b0, 8'h01, 16'h0000, 16'hAB00, "ptr_one_word0");

        // Reset during WAIT discards the pending write.
        bus_op(1'b1, 8'h10, 16'h1357, 16'hAB00, "pre_write");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'h10; din = 16'hAAAA;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rdy", 32'(rdy), 32'd0);
        check("rst_mid_out", 32'(dout), 32'd0);
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (rdy) bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rdy) bad++;
        end
        check("rst_no_ready", 32'(bad), 32'd0);
        bus_op(1'b0, 8'h10, 16'h0000, 16'h1357, "rst_retained");

        // Zero wait states, mem_req held high: back-to-back one-cycle pulses.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
        pat = '0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            pat[5-e] = rdy0;
        end
        @(negedge clk);
        req0 = 1'b0;
        check("ws0_pulse_pattern", 32'(pat), 32'h2A);

        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; din0 = 16'h4242;
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0;
        check("ws0_write_rdy", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        check("ws0_write_rdy_low", 32'(rdy0), 32'd0);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h21;
        @(posedge clk); #1;
        req0 = 1'b0;
        check("ws0_read_rdy", 32'(rdy0), 32'd1);
        check("ws0_read_data", 32'(dout0), 32'h4242);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
